// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and step-result flag type for param_updown_counter
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  // Width-independent part of a step result; the count field is added by the
  // counter itself, since its width is a per-instance parameter.
  typedef struct packed {
    logic ovf;
    logic unf;
  } step_flags_t;

endpackage

// File: rtl/count_prescaler.sv
// rtl/count_prescaler.sv - enable divider producing one step per DIV enabled cycles
module count_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_step
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0] r_phase;
  logic          w_last;

  assign w_last = (r_phase == PW'(DIV - 1));
  assign o_step = i_enable & w_last;

  // Phase only advances on enabled cycles, so it freezes while enable is low.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_phase <= '0;
    end else if (i_enable) begin
      r_phase <= w_last ? '0 : r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - up/down wrap/saturate counter; optional prescaler via COUNTER_PRESCALE_EN
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH        = 4,
  parameter int unsigned RESET_VALUE  = 0,
  parameter int          PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             err_clr,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out,
  output logic             underflow_out,
  output logic             at_limit,
  output logic             at_zero,
  output logic             err_sticky
);

  typedef struct packed {
    logic [WIDTH-1:0] count;
    step_flags_t      flags;
  } step_result_t;

  if (WIDTH < 2 || WIDTH > 32 || PRESCALE_DIV < 2 || PRESCALE_DIV > 256) begin : g_bad_param
    $error("param_updown_counter: WIDTH or PRESCALE_DIV out of range");
  end

  // A count above limit (limit lowered at runtime) is treated as at-limit going up.
  function automatic step_result_t next_step(
    input logic [WIDTH-1:0] cnt,
    input logic [WIDTH-1:0] lim,
    input logic             dir,
    input logic             md
  );
    step_result_t res;
    res.count = cnt;
    res.flags = '0;
    if (dir == DIR_UP) begin
      if (cnt >= lim) begin
        res.flags.ovf = 1'b1;
        res.count     = (md == MODE_SAT) ? lim : '0;
      end else begin
        res.count = cnt + 1'b1;
      end
    end else begin
      if (cnt == '0) begin
        res.flags.unf = 1'b1;
        res.count     = (md == MODE_SAT) ? '0 : lim;
      end else begin
        res.count = cnt - 1'b1;
      end
    end
    return res;
  endfunction

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             r_err;

  logic             w_step;
  step_result_t     w_res;
  logic [WIDTH-1:0] w_load_count;
  logic             w_ovf_next;
  logic             w_unf_next;

`ifdef COUNTER_PRESCALE_EN
  count_prescaler #(
    .DIV(PRESCALE_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .i_clear (load),
    .i_enable(enable),
    .o_step  (w_step)
  );
`else
  assign w_step = enable;
`endif

  assign w_res        = next_step(r_count, limit, up_down, mode);
  assign w_load_count = (load_value > limit) ? limit : load_value;
  assign w_ovf_next   = w_step & ~load & w_res.flags.ovf;
  assign w_unf_next   = w_step & ~load & w_res.flags.unf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= WIDTH'(RESET_VALUE);
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ovf <= w_ovf_next;
      r_unf <= w_unf_next;
      // A new event wins over a simultaneous clear.
      r_err <= (r_err & ~err_clr) | w_ovf_next | w_unf_next;
      if (load) begin
        r_count <= w_load_count;
      end else if (w_step) begin
        r_count <= w_res.count;
      end
    end
  end

  assign counter_out   = r_count;
  assign overflow_out  = r_ovf;
  assign underflow_out = r_unf;
  assign err_sticky    = r_err;
  assign at_limit      = (r_count == limit);
  assign at_zero       = (r_count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - self-checking bench for param_updown_counter
module tb_param_updown_counter;

  localparam int W   = 4;
  localparam int RV  = 0;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         reset, enable, up_down, mode, load, err_clr;
  logic [W-1:0] limit, load_value, counter_out;
  logic         overflow_out, underflow_out, at_limit, at_zero, err_sticky;

  int total = 0;
  int bad   = 0;

  int m_count;
  bit m_ovf, m_unf, m_err;
  int m_en;

  typedef struct {
    bit rst; bit en; bit up; bit md; int lim; bit ld; int lv; bit clr;
    int ec;  bit eo; bit eu; bit ee;
  } vec_t;

  vec_t tbl[$];

  param_updown_counter #(
    .WIDTH(W), .RESET_VALUE(RV), .PRESCALE_DIV(DIV)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .mode(mode),
    .limit(limit), .load(load), .load_value(load_value), .err_clr(err_clr),
    .counter_out(counter_out), .overflow_out(overflow_out),
    .underflow_out(underflow_out), .at_limit(at_limit), .at_zero(at_zero),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the counting rules, using integer arithmetic.
  task automatic model_edge();
    int  l;
    bit  do_step;
    l = int'(limit);
    if (reset) begin
      m_count = RV; m_ovf = 0; m_unf = 0; m_err = 0; m_en = 0;
    end else if (load) begin
      m_count = (int'(load_value) < l) ? int'(load_value) : l;
      m_ovf = 0; m_unf = 0; m_en = 0;
      m_err = m_err && !err_clr;
    end else begin
`ifdef COUNTER_PRESCALE_EN
      do_step = 0;
      if (enable) begin
        m_en++;
        do_step = (m_en % DIV) == 0;
      end
`else
      do_step = enable;
`endif
      m_ovf = 0; m_unf = 0;
      if (do_step) begin
        if (up_down) begin
          m_ovf = (m_count >= l);
          if (mode) m_count = m_ovf ? l : m_count + 1;
          else      m_count = ((m_ovf ? l : m_count) + 1) % (l + 1);
        end else begin
          m_unf = (m_count == 0);
          if (m_unf) m_count = mode ? 0 : l;
          else       m_count = m_count - 1;
        end
      end
      m_err = (m_err && !err_clr) || m_ovf || m_unf;
    end
  endtask

  task automatic apply(input bit r, input bit e, input bit u, input bit m,
                       input int l, input bit ld, input int lv, input bit c);
    reset = r; enable = e; up_down = u; mode = m;
    limit = W'(l); load = ld; load_value = W'(lv); err_clr = c;
    model_edge();
    @(posedge clk);
    #1;
    chk("model_count", int'(counter_out), m_count);
    chk("model_ovf", int'(overflow_out), int'(m_ovf));
    chk("model_unf", int'(underflow_out), int'(m_unf));
    chk("model_err", int'(err_sticky), int'(m_err));
    chk("model_at_limit", int'(at_limit), int'(m_count == l));
    chk("model_at_zero", int'(at_zero), int'(m_count == 0));
  endtask

  initial begin
    int n;
    int cur_lim;
    bit cur_mode;

    reset = 1; enable = 0; up_down = 1; mode = 0; limit = '1;
    load = 0; load_value = '0; err_clr = 0;
    m_count = RV; m_ovf = 0; m_unf = 0; m_err = 0; m_en = 0;

    apply(1, 0, 1, 0, 15, 0, 0, 0);
    chk("reset_count", int'(counter_out), RV);
    chk("reset_err", int'(err_sticky), 0);

`ifndef COUNTER_PRESCALE_EN
    for (int i = 1; i <= 20; i++) begin
      apply(0, 1, 1, 0, 15, 0, 0, 0);
      chk("t1_count", int'(counter_out), i % 16);
      chk("t1_ovf", int'(overflow_out), int'(i == 16));
    end
    chk("t1_err", int'(err_sticky), 1);

    tbl.push_back('{1,0,1,0, 9,0, 0,0,  0,0,0,0});
    tbl.push_back('{0,0,1,1, 9,1, 7,0,  7,0,0,0});
    tbl.push_back('{0,1,1,1, 9,0, 0,0,  8,0,0,0});
    tbl.push_back('{0,1,1,1, 9,0, 0,0,  9,0,0,0});
    tbl.push_back('{0,1,1,1, 9,0, 0,0,  9,1,0,1});
    tbl.push_back('{0,1,1,1, 9,0, 0,0,  9,1,0,1});
    tbl.push_back('{0,1,1,1, 9,0, 0,0,  9,1,0,1});
    tbl.push_back('{0,0,1,1, 9,0, 0,0,  9,0,0,1});
    tbl.push_back('{1,0,0,0, 5,0, 0,0,  0,0,0,0});
    tbl.push_back('{0,1,0,0, 5,0, 0,0,  5,0,1,1});
    tbl.push_back('{0,1,0,0, 5,0, 0,0,  4,0,0,1});
    tbl.push_back('{0,1,0,0, 5,0, 0,0,  3,0,0,1});
    tbl.push_back('{0,1,1,0,10,1,12,0, 10,0,0,1});
    tbl.push_back('{0,1,1,0,10,0, 0,1,  0,1,0,1});
    tbl.push_back('{0,0,1,0,10,0, 0,1,  0,0,0,0});
    tbl.push_back('{0,0,1,0,10,1, 6,0,  6,0,0,0});
    tbl.push_back('{1,1,1,0,10,1, 9,0,  0,0,0,0});
    tbl.push_back('{0,0,1,0,10,1, 6,0,  6,0,0,0});
    tbl.push_back('{0,1,1,0, 3,0, 0,0,  0,1,0,1});
    tbl.push_back('{0,0,1,1,10,1, 8,0,  8,0,0,1});
    tbl.push_back('{0,1,0,1, 3,0, 0,0,  7,0,0,1});
    tbl.push_back('{0,1,1,1, 3,0, 0,0,  3,1,0,1});
    tbl.push_back('{0,1,1,0, 0,0, 0,0,  0,1,0,1});
    tbl.push_back('{0,1,0,1, 0,0, 0,0,  0,0,1,1});
    tbl.push_back('{0,1,1,1, 0,0, 0,0,  0,1,0,1});

    foreach (tbl[k]) begin
      apply(tbl[k].rst, tbl[k].en, tbl[k].up, tbl[k].md, tbl[k].lim,
            tbl[k].ld, tbl[k].lv, tbl[k].clr);
      chk($sformatf("tbl%0d_count", k), int'(counter_out), tbl[k].ec);
      chk($sformatf("tbl%0d_ovf", k), int'(overflow_out), int'(tbl[k].eo));
      chk($sformatf("tbl%0d_unf", k), int'(underflow_out), int'(tbl[k].eu));
      chk($sformatf("tbl%0d_err", k), int'(err_sticky), int'(tbl[k].ee));
    end
`else
    n = 0;
    for (int i = 0; i < 12; i++) begin
      apply(0, 1, 1, 0, 15, 0, 0, 0);
      n++;
      chk("t6_count", int'(counter_out), n / DIV);
    end
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 1, 0, 15, 0, 0, 0);
      chk("t6_hold", int'(counter_out), 3);
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 1, 0, 15, 0, 0, 0);
      n++;
      chk("t6_resume", int'(counter_out), n / DIV);
    end
`endif

    cur_lim  = 15;
    cur_mode = 0;
    apply(1, 0, 1, 0, cur_lim, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) cur_lim = $urandom_range(0, 15);
      if ($urandom_range(0, 29) == 0) cur_mode = ~cur_mode;
      apply($urandom_range(0, 49) == 0,
            $urandom_range(0, 4) != 0,
            $urandom_range(0, 2) != 0,
            cur_mode,
            cur_lim,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 15),
            $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
